icache_arbiter: RTL and testbench
=================================

// Module: icache_arbiter
// PURPOSE
// Shares the single icache address/data valid-ready port between N_REQ fetch requesters
// (e.g. IF fetch interface and next-line prefetcher). Arbitrates address requests, registers
// an unaccepted grant so requesters are released immediately, tags every accepted request
// with its owner in an in-order queue, routes returned icache_out_t to the owner, and
// silently drains responses killed by flush_i. Sits between the fetch interfaces and icache.
// PARAMETERS
// N_REQ      2  number of requesters (>=2); ID_W = $clog2(N_REQ)
// MAX_OUTST  2  max accepted-but-unanswered icache requests (owner queue depth, >=1)
// FIXED_PRIO 0  0: round-robin; 1: fixed priority, lowest index wins
// PORTS
// clk_i        in   1                  clock, rising edge
// rst_i        in   1                  reset: one clock; reset is asynchronous and active-high
// flush_i      in   1                  kill all in-flight requests (pipeline flush)
// req_addr_i   in   N_REQ*XLEN         per-requester fetch address, requester k at [k*XLEN+:XLEN]
// req_valid_i  in   N_REQ              per-requester address valid
// req_ready_o  out  N_REQ              per-requester address accepted (one-hot or zero)
// rsp_data_o   out  $bits(icache_out_t) response data, broadcast to all requesters
// rsp_valid_o  out  N_REQ              response valid, one-hot at owner of queue head
// rsp_ready_i  in   N_REQ              per-requester response ready
// addr_o       out  XLEN               address to icache
// addr_valid_o out  1                  address valid to icache
// addr_ready_i in   1                  icache accepts address
// data_i       in   $bits(icache_out_t) icache response
// data_valid_i in   1                  icache response valid
// data_ready_o out  1                  arbiter accepts response
// BEHAVIOUR
// - Reset: state ARB, queue empty (cnt=0), rr_ptr=0, hold regs 0; all outputs 0 while rst_i.
// - State ARB: if !flush_i && cnt<MAX_OUTST and any req_valid_i: grant g (RR: first valid at
//   or after rr_ptr, wrapping; FIXED: lowest valid index). Same cycle: req_ready_o[g]=1,
//   addr_o=req_addr_i[g], addr_valid_o=1. addr_ready_i=1 -> push {g,kill=0}, stay ARB;
//   else latch addr/g into hold regs, hold_kill=0, go HOLD. Requester handshake is complete
//   at grant regardless of addr_ready_i. RR: rr_ptr <= (g+1) mod N_REQ on every grant.
// - State HOLD: addr_o=held addr, addr_valid_o=1 (must not drop), req_ready_o=0.
//   addr_ready_i=1 -> push {held g, hold_kill}, go ARB (no new grant that cycle).
// - cnt==MAX_OUTST in ARB: addr_valid_o=0, req_ready_o=0. Grant counts against cnt only
//   on push; HOLD entered only from ARB with cnt<MAX_OUTST, so push never overflows.
// - Responses: head valid when cnt>0. Head live: rsp_valid_o[owner]=data_valid_i,
//   rsp_data_o=data_i, data_ready_o=rsp_ready_i[owner]. Head killed: rsp_valid_o=0,
//   data_ready_o=1 (drained). Pop on data_valid_i&&data_ready_o. cnt==0: data_ready_o=0,
//   rsp_valid_o=0 (spurious data is a protocol error; bench asserts it never occurs).
// - Push and pop in same cycle: cnt unchanged; queue wraps modulo MAX_OUTST.
// - rsp_data_o = data_i combinationally at all times (no data register); latency: address
//   0 cycles in ARB with ready, response 0 cycles added.
// - flush_i (sync, 1 cycle): sets kill on every queued entry incl. one pushed that cycle;
//   in HOLD sets hold_kill; in ARB masks grant that cycle. Entry popped same cycle is
//   unaffected. After flush, new grants are live; killed responses drain in order first.
// - rst_i mid-transaction: everything returns to reset values immediately; icache is
//   reset by the same signal.
// TESTING
// 1 Single req0 @0x100, addr_ready_i=1, data 2 cyc later, rsp_ready_i=1 -> req_ready_o=01,
//   addr_o=0x100 same cycle; rsp_valid_o=01 with data; cnt back to 0.
// 2 RR: req_valid_i=11 held 4 grants, addr_ready_i=1, MAX_OUTST=4, no data -> grants
//   0,1,0,1; 5th cycle addr_valid_o=0, req_ready_o=00 (full); FIXED_PRIO=1 -> 0,0,0,0.
// 3 Backpressure: addr_ready_i=0 for 3 cyc after grant of req1 @0x200 -> req_ready_o=10
//   one cycle only, addr_o stays 0x200 with addr_valid_o=1 until ready, then pushed.
// 4 Ordering: req0 then req1 outstanding, rsp_ready_i[0]=0 for 2 cyc -> data_ready_o=0,
//   rsp_valid_o=01 held; then first to req0, second to req1 (rsp_valid_o=10).
// 5 Flush: 2 entries queued + 1 in HOLD, pulse flush_i -> 3 responses drained with
//   data_ready_o=1, rsp_valid_o=00; post-flush req0 @0x300 response delivered to req0.
// 6 Reset mid-HOLD with cnt=1 -> all outputs 0 asynchronously; after release cnt=0,
//   rr_ptr=0, first grant to lowest valid index.

Source files
------------

// File: rtl/icache_arbiter.sv
// rtl/icache_arbiter.sv - shares one icache address/response port between N_REQ fetch requesters
// Requests are tagged with their owner in an in-order queue; flushed entries drain silently.
module icache_arbiter #(
    parameter int N_REQ      = 2,
    parameter int MAX_OUTST  = 2,
    parameter int FIXED_PRIO = 0,
    parameter int XLEN       = 32,
    parameter int DATA_W     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [N_REQ*XLEN-1:0] req_addr_i,
    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    output logic [DATA_W-1:0]     rsp_data_o,
    output logic [N_REQ-1:0]      rsp_valid_o,
    input  logic [N_REQ-1:0]      rsp_ready_i,
    output logic [XLEN-1:0]       addr_o,
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    input  logic [DATA_W-1:0]     data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    localparam logic ST_ARB  = 1'b0;
    localparam logic ST_HOLD = 1'b1;

    logic                 state;
    logic [ID_W-1:0]      rr_ptr;
    logic [CNT_W-1:0]     cnt;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [ID_W-1:0]      owner_q [MAX_OUTST];
    logic                 kill_q  [MAX_OUTST];
    logic [XLEN-1:0]      hold_addr;
    logic [ID_W-1:0]      hold_id;
    logic                 hold_kill;

    logic                 found;
    logic [ID_W-1:0]      gnt;
    logic [N_REQ-1:0]     gnt_oh;
    logic                 can_grant;
    logic                 push;
    logic [ID_W-1:0]      push_id;
    logic                 push_kill;
    logic                 pop;
    logic                 has_head;
    logic [ID_W-1:0]      head_owner;
    logic                 head_kill;
    logic [N_REQ-1:0]     head_oh;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (int'(p) == MAX_OUTST - 1) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scans indices at/after rr_ptr first, then wraps to those below it.
    always_comb begin
        found  = 1'b0;
        gnt    = '0;
        gnt_oh = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req_valid_i[j] && (FIXED_PRIO != 0 || ID_W'(j) >= rr_ptr)) begin
                found     = 1'b1;
                gnt       = ID_W'(j);
                gnt_oh    = '0;
                gnt_oh[j] = 1'b1;
            end
        end
        if (FIXED_PRIO == 0) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req_valid_i[j] && ID_W'(j) < rr_ptr) begin
                    found     = 1'b1;
                    gnt       = ID_W'(j);
                    gnt_oh    = '0;
                    gnt_oh[j] = 1'b1;
                end
            end
        end
    end

    assign can_grant  = (state == ST_ARB) && !flush_i && (cnt < CNT_W'(MAX_OUTST)) && found;
    assign push       = (state == ST_HOLD) ? addr_ready_i : (can_grant && addr_ready_i);
    assign push_id    = (state == ST_HOLD) ? hold_id : gnt;
    assign push_kill  = (state == ST_HOLD) ? (hold_kill || flush_i) : 1'b0;

    assign has_head   = (cnt != '0);
    assign head_owner = owner_q[rd_ptr];
    assign head_kill  = kill_q[rd_ptr];

    always_comb begin
        head_oh             = '0;
        head_oh[head_owner] = 1'b1;
    end

    always_comb begin
        req_ready_o  = '0;
        rsp_data_o   = '0;
        rsp_valid_o  = '0;
        addr_o       = '0;
        addr_valid_o = 1'b0;
        data_ready_o = 1'b0;
        if (!rst_i) begin
            rsp_data_o = data_i;
            if (state == ST_HOLD) begin
                addr_o       = hold_addr;
                addr_valid_o = 1'b1;
            end else if (can_grant) begin
                req_ready_o  = gnt_oh;
                addr_o       = req_addr_i[int'(gnt)*XLEN +: XLEN];
                addr_valid_o = 1'b1;
            end
            if (has_head) begin
                if (head_kill) begin
                    data_ready_o = 1'b1;
                end else begin
                    rsp_valid_o  = data_valid_i ? head_oh : '0;
                    data_ready_o = rsp_ready_i[head_owner];
                end
            end
        end
    end

    assign pop = data_valid_i && data_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= ST_ARB;
            rr_ptr    <= '0;
            cnt       <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            hold_addr <= '0;
            hold_id   <= '0;
            hold_kill <= 1'b0;
            for (int i = 0; i < MAX_OUTST; i++) begin
                owner_q[i] <= '0;
                kill_q[i]  <= 1'b0;
            end
        end else begin
            // A flush kills everything queued; a same-cycle push carries the kill in push_kill.
            if (flush_i) begin
                for (int i = 0; i < MAX_OUTST; i++) begin
                    kill_q[i] <= 1'b1;
                end
            end
            if (push) begin
                owner_q[wr_ptr] <= push_id;
                kill_q[wr_ptr]  <= push_kill;
                wr_ptr          <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (!push && pop) begin
                cnt <= cnt - 1'b1;
            end

            if (can_grant) begin
                rr_ptr <= (int'(gnt) == N_REQ - 1) ? '0 : gnt + 1'b1;
            end

            case (state)
                ST_ARB: begin
                    if (can_grant && !addr_ready_i) begin
                        hold_addr <= req_addr_i[int'(gnt)*XLEN +: XLEN];
                        hold_id   <= gnt;
                        hold_kill <= 1'b0;
                        state     <= ST_HOLD;
                    end
                end
                default: begin
                    if (flush_i) begin
                        hold_kill <= 1'b1;
                    end
                    if (addr_ready_i) begin
                        state <= ST_ARB;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_arbiter.sv
// tb/tb_icache_arbiter.sv - directed scoreboard bench for icache_arbiter
module tb_icache_arbiter;

    localparam int XLEN   = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [2*XLEN-1:0] req_addr;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready, req_ready_f;
    logic [DATA_W-1:0] rsp_data, rsp_data_f;
    logic [1:0]        rsp_valid, rsp_valid_f;
    logic [1:0]        rsp_ready;
    logic [XLEN-1:0]   addr, addr_f;
    logic              addr_valid, addr_valid_f;
    logic              addr_ready;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              data_ready, data_ready_f;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic owner;
        logic kill;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    icache_arbiter #(.N_REQ(2), .MAX_OUTST(4), .FIXED_PRIO(0), .XLEN(XLEN), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .rsp_data_o(rsp_data), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .addr_o(addr), .addr_valid_o(addr_valid), .addr_ready_i(addr_ready),
        .data_i(data), .data_valid_i(data_valid), .data_ready_o(data_ready)
    );

    icache_arbiter #(.N_REQ(2), .MAX_OUTST(4), .FIXED_PRIO(1), .XLEN(XLEN), .DATA_W(DATA_W)) dut_f (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .req_addr_i(req_addr), .req_valid_i(req_valid), .req_ready_o(req_ready_f),
        .rsp_data_o(rsp_data_f), .rsp_valid_o(rsp_valid_f), .rsp_ready_i(rsp_ready),
        .addr_o(addr_f), .addr_valid_o(addr_valid_f), .addr_ready_i(addr_ready),
        .data_i(data), .data_valid_i(data_valid), .data_ready_o(data_ready_f)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One response beat: pop the expected owner and compare what the arbiter presents.
    task automatic resp_beat(input string tag, input logic [31:0] d, input logic [1:0] rr);
        sb_t e;
        rsp_ready  = rr;
        data       = d;
        data_valid = 1'b1;
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_spurious"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            if (e.kill) begin
                chk({tag, "_kill_valid"}, rsp_valid, 2'b00);
                chk({tag, "_kill_ready"}, data_ready, 1'b1);
            end else begin
                chk({tag, "_valid"}, rsp_valid, e.owner ? 2'b10 : 2'b01);
                chk({tag, "_data"}, rsp_data, d);
                chk({tag, "_ready"}, data_ready, rr[e.owner]);
            end
        end
        tick();
        data_valid = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        req_addr   = '0;
        req_valid  = '0;
        rsp_ready  = '0;
        addr_ready = 1'b0;
        data       = '0;
        data_valid = 1'b0;
        #2;
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_addr_valid", addr_valid, 1'b0);
        chk("rst_data_ready", data_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 2'b00);
        tick();
        tick();
        rst = 1'b0;

        // Round-robin vs fixed priority until the owner queue fills
        req_addr   = {32'h0000_0180, 32'h0000_0080};
        req_valid  = 2'b11;
        addr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("rr_grant%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("fixed_grant%0d", k), req_ready_f, 2'b01);
            tick();
        end
        #1;
        chk("full_addr_valid", addr_valid, 1'b0);
        chk("full_req_ready", req_ready, 2'b00);
        chk("full_addr_valid_fixed", addr_valid_f, 1'b0);
        req_valid = 2'b00;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();

        // Single request from req0
        req_addr  = {32'h0, 32'h0000_0100};
        req_valid = 2'b01;
        #1;
        chk("t1_req_ready", req_ready, 2'b01);
        chk("t1_addr", addr, 32'h100);
        chk("t1_addr_valid", addr_valid, 1'b1);
        sb.push_back('{owner: 1'b0, kill: 1'b0});
        tick();
        req_valid = 2'b00;
        tick();
        resp_beat("t1_rsp", 32'hA1, 2'b11);
        chk("t1_cnt", dut.cnt, 0);

        // Backpressure on the icache address port
        req_addr   = {32'h0000_0200, 32'h0};
        req_valid  = 2'b10;
        addr_ready = 1'b0;
        #1;
        chk("t3_req_ready", req_ready, 2'b10);
        chk("t3_addr", addr, 32'h200);
        tick();
        req_valid = 2'b00;
        req_addr  = {32'hDEAD_0000, 32'h0};
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("t3_hold_ready%0d", k), req_ready, 2'b00);
            chk($sformatf("t3_hold_addr%0d", k), addr, 32'h200);
            chk($sformatf("t3_hold_valid%0d", k), addr_valid, 1'b1);
            tick();
        end
        addr_ready = 1'b1;
        #1;
        chk("t3_accept_valid", addr_valid, 1'b1);
        chk("t3_accept_addr", addr, 32'h200);
        sb.push_back('{owner: 1'b1, kill: 1'b0});
        tick();
        chk("t3_after_valid", addr_valid, 1'b0);
        resp_beat("t3_rsp", 32'hB2, 2'b11);

        // In-order delivery with a stalled owner
        req_addr  = {32'h0000_0440, 32'h0000_0400};
        req_valid = 2'b01;
        #1;
        chk("t4_grant0", req_ready, 2'b01);
        sb.push_back('{owner: 1'b0, kill: 1'b0});
        tick();
        req_valid = 2'b10;
        #1;
        chk("t4_grant1", req_ready, 2'b10);
        sb.push_back('{owner: 1'b1, kill: 1'b0});
        tick();
        req_valid  = 2'b00;
        rsp_ready  = 2'b10;
        data       = 32'hC3;
        data_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("t4_stall_ready%0d", k), data_ready, 1'b0);
            chk($sformatf("t4_stall_valid%0d", k), rsp_valid, 2'b01);
            tick();
        end
        resp_beat("t4_rsp0", 32'hC3, 2'b11);
        resp_beat("t4_rsp1", 32'hC4, 2'b11);

        // Flush with two queued entries and one held address
        req_addr  = {32'h0000_0520, 32'h0000_0500};
        req_valid = 2'b01;
        #1;
        chk("t5_grant_a", req_ready, 2'b01);
        sb.push_back('{owner: 1'b0, kill: 1'b0});
        tick();
        req_valid = 2'b10;
        #1;
        chk("t5_grant_b", req_ready, 2'b10);
        sb.push_back('{owner: 1'b1, kill: 1'b0});
        tick();
        req_addr   = {32'h0, 32'h0000_0540};
        req_valid  = 2'b01;
        addr_ready = 1'b0;
        #1;
        chk("t5_grant_hold", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        flush     = 1'b1;
        #1;
        chk("t5_flush_hold_valid", addr_valid, 1'b1);
        chk("t5_flush_hold_addr", addr, 32'h540);
        for (int i = 0; i < sb.size(); i++) sb[i].kill = 1'b1;
        tick();
        flush      = 1'b0;
        addr_ready = 1'b1;
        #1;
        chk("t5_hold_push_valid", addr_valid, 1'b1);
        sb.push_back('{owner: 1'b0, kill: 1'b1});
        tick();
        for (int k = 0; k < 3; k++) resp_beat($sformatf("t5_drain%0d", k), 32'hD0 + k, 2'b00);
        flush     = 1'b1;
        req_addr  = {32'h0, 32'h0000_0300};
        req_valid = 2'b01;
        #1;
        chk("t5_flush_mask_ready", req_ready, 2'b00);
        chk("t5_flush_mask_valid", addr_valid, 1'b0);
        tick();
        flush = 1'b0;
        #1;
        chk("t5_post_grant", req_ready, 2'b01);
        chk("t5_post_addr", addr, 32'h300);
        sb.push_back('{owner: 1'b0, kill: 1'b0});
        tick();
        req_valid = 2'b00;
        resp_beat("t5_post_rsp", 32'hE5, 2'b01);

        // Asynchronous reset while an address is held and one entry is queued
        req_addr  = {32'h0000_0600, 32'h0000_0640};
        req_valid = 2'b10;
        #1;
        chk("t6_grant1", req_ready, 2'b10);
        tick();
        req_valid  = 2'b01;
        addr_ready = 1'b0;
        #1;
        chk("t6_grant0", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        data      = 32'hFF;
        #1;
        chk("t6_hold_valid", addr_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_rst_addr_valid", addr_valid, 1'b0);
        chk("t6_rst_addr", addr, 32'h0);
        chk("t6_rst_req_ready", req_ready, 2'b00);
        chk("t6_rst_data_ready", data_ready, 1'b0);
        chk("t6_rst_rsp_valid", rsp_valid, 2'b00);
        chk("t6_rst_rsp_data", rsp_data, 32'h0);
        sb.delete();
        tick();
        rst = 1'b0;
        #1;
        chk("t6_cnt", dut.cnt, 0);
        chk("t6_rr_ptr", dut.rr_ptr, 0);
        req_valid  = 2'b11;
        addr_ready = 1'b1;
        #1;
        chk("t6_first_grant", req_ready, 2'b01);
        chk("t6_first_addr", addr, 32'h640);
        sb.push_back('{owner: 1'b0, kill: 1'b0});
        tick();
        req_valid = 2'b00;
        resp_beat("t6_rsp", 32'hF6, 2'b11);
        chk("end_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
